// File: rtl/lmi_dfill_resp_pkg.sv
// rtl/lmi_dfill_resp_pkg.sv - shared state encodings and line geometry for the LMI dcache fill responder
package lmi_dfill_resp_pkg;

    // Responder sequencing states
    typedef enum logic [1:0] {
        RSP_ST_IDLE = 2'd0,
        RSP_ST_RD   = 2'd1,
        RSP_ST_WR   = 2'd2
    } rsp_state_e;

    // Cache line geometry seen by the LMI port
    localparam int LMI_LINE_WORDS = 4;
    localparam int LMI_OFS_W      = $clog2(LMI_LINE_WORDS);

endpackage

// File: rtl/lmi_dfill_resp.sv
// rtl/lmi_dfill_resp.sv - LMI memory-side responder: line fills, uncached reads and single-word writes
//
// Sequences dcache requests onto a single-port, variable-latency memory.
// Ports:
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   REQ_VAL/REQ_RDY                   request handshake (REQ_RDY high only in IDLE)
//   REQ_LINE, REQ_WR, REQ_ADDR,
//   REQ_WDATA                         request kind, word address, write data
//   MEM_REQ, MEM_WE, MEM_ADDR,
//   MEM_WDATA                         registered memory access
//   MEM_RDY, MEM_RDATA                access completion and read data
//   DS_VAL, DS_DATA, DS_WORD, DS_LAST returned read word stream (critical word first)
//   WR_ACK                            one-cycle write completion pulse
module lmi_dfill_resp
    import lmi_dfill_resp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int LINE_WORDS = LMI_LINE_WORDS,
    parameter int OFS_W      = LMI_OFS_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VAL,
    output logic              REQ_RDY,
    input  logic              REQ_LINE,
    input  logic              REQ_WR,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_RDY,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              DS_VAL,
    output logic [DATA_W-1:0] DS_DATA,
    output logic [OFS_W-1:0]  DS_WORD,
    output logic              DS_LAST,
    output logic              WR_ACK
);

    localparam int BASE_W = ADDR_W - OFS_W;
    // Remaining-word counter must hold the full LINE_WORDS value
    localparam int CNT_W  = OFS_W + 1;

    rsp_state_e        r_state, w_state_nxt;
    logic [BASE_W-1:0] r_base,  w_base_nxt;
    logic [OFS_W-1:0]  r_ofs,   w_ofs_nxt;
    logic [CNT_W-1:0]  r_rem,   w_rem_nxt;

    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_ds_val,    w_ds_val_nxt;
    logic [DATA_W-1:0] r_ds_data,   w_ds_data_nxt;
    logic [OFS_W-1:0]  r_ds_word,   w_ds_word_nxt;
    logic              r_ds_last,   w_ds_last_nxt;
    logic              r_wr_ack,    w_wr_ack_nxt;

    // Offset wraps modulo LINE_WORDS through natural OFS_W-bit overflow
    logic [OFS_W-1:0]  w_ofs_inc;
    logic              w_last_word;

    assign w_ofs_inc   = r_ofs + 1'b1;
    assign w_last_word = (r_rem == CNT_W'(1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= RSP_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_ofs_nxt       = r_ofs;
        w_rem_nxt       = r_rem;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ds_val_nxt    = 1'b0;
        w_ds_data_nxt   = r_ds_data;
        w_ds_word_nxt   = r_ds_word;
        w_ds_last_nxt   = 1'b0;
        w_wr_ack_nxt    = 1'b0;

        case (r_state)
            RSP_ST_IDLE: begin
                if (REQ_VAL) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = REQ_ADDR;
                    if (REQ_WR) begin
                        w_state_nxt     = RSP_ST_WR;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = REQ_WDATA;
                    end else begin
                        w_state_nxt  = RSP_ST_RD;
                        w_mem_we_nxt = 1'b0;
                        w_base_nxt   = REQ_ADDR[ADDR_W-1:OFS_W];
                        w_ofs_nxt    = REQ_ADDR[OFS_W-1:0];
                        w_rem_nxt    = REQ_LINE ? CNT_W'(LINE_WORDS) : CNT_W'(1);
                    end
                end
            end

            RSP_ST_RD: begin
                if (MEM_RDY) begin
                    w_ds_val_nxt  = 1'b1;
                    w_ds_data_nxt = MEM_RDATA;
                    w_ds_word_nxt = r_ofs;
                    w_ds_last_nxt = w_last_word;
                    w_ofs_nxt     = w_ofs_inc;
                    w_rem_nxt     = r_rem - 1'b1;
                    if (w_last_word) begin
                        w_state_nxt   = RSP_ST_IDLE;
                        w_mem_req_nxt = 1'b0;
                    end else begin
                        // Line base is fixed; only the offset advances
                        w_mem_addr_nxt = {r_base, w_ofs_inc};
                    end
                end
            end

            RSP_ST_WR: begin
                if (MEM_RDY) begin
                    w_state_nxt   = RSP_ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_wr_ack_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = RSP_ST_IDLE;
                w_mem_req_nxt = 1'b0;
                w_mem_we_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_base      <= '0;
            r_ofs       <= '0;
            r_rem       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ds_val    <= 1'b0;
            r_ds_data   <= '0;
            r_ds_word   <= '0;
            r_ds_last   <= 1'b0;
            r_wr_ack    <= 1'b0;
        end else begin
            r_base      <= w_base_nxt;
            r_ofs       <= w_ofs_nxt;
            r_rem       <= w_rem_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ds_val    <= w_ds_val_nxt;
            r_ds_data   <= w_ds_data_nxt;
            r_ds_word   <= w_ds_word_nxt;
            r_ds_last   <= w_ds_last_nxt;
            r_wr_ack    <= w_wr_ack_nxt;
        end
    end

    assign REQ_RDY   = (r_state == RSP_ST_IDLE);
    assign MEM_REQ   = r_mem_req;
    assign MEM_WE    = r_mem_we;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign DS_VAL    = r_ds_val;
    assign DS_DATA   = r_ds_data;
    assign DS_WORD   = r_ds_word;
    assign DS_LAST   = r_ds_last;
    assign WR_ACK    = r_wr_ack;

endmodule

// File: tb/tb_lmi_dfill_resp.sv
// tb/tb_lmi_dfill_resp.sv - self-checking bench for lmi_dfill_resp
module tb_lmi_dfill_resp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int LW     = 4;
    localparam int OFS_W  = 2;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              REQ_VAL = 1'b0;
    logic              REQ_RDY;
    logic              REQ_LINE = 1'b0;
    logic              REQ_WR = 1'b0;
    logic [ADDR_W-1:0] REQ_ADDR = '0;
    logic [DATA_W-1:0] REQ_WDATA = '0;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_RDY = 1'b0;
    logic [DATA_W-1:0] MEM_RDATA = '0;
    logic              DS_VAL;
    logic [DATA_W-1:0] DS_DATA;
    logic [OFS_W-1:0]  DS_WORD;
    logic              DS_LAST;
    logic              WR_ACK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] g_key    = 32'h0;

    lmi_dfill_resp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LW), .OFS_W(OFS_W)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VAL(REQ_VAL), .REQ_RDY(REQ_RDY), .REQ_LINE(REQ_LINE), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDY(MEM_RDY), .MEM_RDATA(MEM_RDATA),
        .DS_VAL(DS_VAL), .DS_DATA(DS_DATA), .DS_WORD(DS_WORD), .DS_LAST(DS_LAST),
        .WR_ACK(WR_ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents model: a fixed scramble of the word address
    function automatic logic [31:0] mdata(input logic [ADDR_W-1:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ g_key;
    endfunction

    // Full read transaction starting at a negedge with the responder idle;
    // returns at the negedge on which the final word is presented.
    task automatic run_read(input logic [ADDR_W-1:0] addr, input bit line,
                            input int minw, input int maxw, input string tag);
        logic [ADDR_W-1:0] seq[$];
        logic [ADDR_W-1:0] base;
        int                n;
        int                s;
        int                w;
        logic              e_val;
        n    = line ? LW : 1;
        s    = int'(addr % ADDR_W'(LW));
        base = addr - ADDR_W'(s);
        for (int i = 0; i < n; i++) seq.push_back(base + ADDR_W'((s + i) % LW));

        n_checks++;
        if (REQ_RDY !== 1'b1) begin n_fail++; $display("FAIL %s req_rdy_idle: got %b exp 1", tag, REQ_RDY); end
        REQ_VAL = 1'b1; REQ_WR = 1'b0; REQ_LINE = line; REQ_ADDR = addr; REQ_WDATA = $urandom;
        @(negedge CLK);
        REQ_VAL = 1'b0; REQ_LINE = 1'($urandom); REQ_ADDR = ADDR_W'($urandom);
        for (int i = 0; i < n; i++) begin
            w = $urandom_range(minw, maxw);
            for (int k = 0; k <= w; k++) begin
                n_checks++;
                if ({MEM_REQ, MEM_WE, REQ_RDY, WR_ACK, MEM_ADDR} !== {1'b1, 1'b0, 1'b0, 1'b0, seq[i]}) begin
                    n_fail++;
                    $display("FAIL %s mem_access w%0d: got req=%b we=%b rdy=%b ack=%b addr=%h exp 1 0 0 0 %h",
                             tag, i, MEM_REQ, MEM_WE, REQ_RDY, WR_ACK, MEM_ADDR, seq[i]);
                end
                e_val = (k == 0 && i > 0);
                n_checks++;
                if (DS_VAL !== e_val) begin n_fail++; $display("FAIL %s ds_val w%0d c%0d: got %b exp %b", tag, i, k, DS_VAL, e_val); end
                if (e_val) begin
                    n_checks++;
                    if ({DS_DATA, DS_WORD, DS_LAST} !== {mdata(seq[i-1]), OFS_W'((s + i - 1) % LW), 1'b0}) begin
                        n_fail++;
                        $display("FAIL %s ds_word w%0d: got %h/%0d/%b exp %h/%0d/0", tag, i - 1,
                                 DS_DATA, DS_WORD, DS_LAST, mdata(seq[i-1]), (s + i - 1) % LW);
                    end
                end
                MEM_RDY   = (k == w);
                MEM_RDATA = (k == w) ? mdata(seq[i]) : $urandom;
                @(negedge CLK);
            end
        end
        MEM_RDY = 1'b0;
        n_checks++;
        if ({DS_VAL, DS_DATA, DS_WORD, DS_LAST, WR_ACK, MEM_REQ, REQ_RDY} !==
            {1'b1, mdata(seq[n-1]), OFS_W'((s + n - 1) % LW), 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s final: got val=%b data=%h word=%0d last=%b ack=%b req=%b rdy=%b exp 1 %h %0d 1 0 0 1",
                     tag, DS_VAL, DS_DATA, DS_WORD, DS_LAST, WR_ACK, MEM_REQ, REQ_RDY,
                     mdata(seq[n-1]), (s + n - 1) % LW);
        end
    endtask

    task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input int minw, input int maxw, input string tag);
        int w;
        n_checks++;
        if (REQ_RDY !== 1'b1) begin n_fail++; $display("FAIL %s req_rdy_idle: got %b exp 1", tag, REQ_RDY); end
        REQ_VAL = 1'b1; REQ_WR = 1'b1; REQ_LINE = 1'($urandom); REQ_ADDR = addr; REQ_WDATA = data;
        @(negedge CLK);
        REQ_VAL = 1'b0; REQ_WR = 1'b0; REQ_ADDR = ADDR_W'($urandom); REQ_WDATA = $urandom;
        w = $urandom_range(minw, maxw);
        for (int k = 0; k <= w; k++) begin
            n_checks++;
            if ({MEM_REQ, MEM_WE, REQ_RDY, DS_VAL, WR_ACK, MEM_ADDR, MEM_WDATA} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, addr, data}) begin
                n_fail++;
                $display("FAIL %s wr_access c%0d: got req=%b we=%b rdy=%b dsv=%b ack=%b addr=%h wd=%h exp 1 1 0 0 0 %h %h",
                         tag, k, MEM_REQ, MEM_WE, REQ_RDY, DS_VAL, WR_ACK, MEM_ADDR, MEM_WDATA, addr, data);
            end
            MEM_RDY   = (k == w);
            MEM_RDATA = $urandom;
            @(negedge CLK);
        end
        MEM_RDY = 1'b0;
        n_checks++;
        if ({WR_ACK, DS_VAL, MEM_REQ, MEM_WE, REQ_RDY} !== 5'b10001) begin
            n_fail++;
            $display("FAIL %s wr_ack: got ack=%b dsv=%b req=%b we=%b rdy=%b exp 1 0 0 0 1",
                     tag, WR_ACK, DS_VAL, MEM_REQ, MEM_WE, REQ_RDY);
        end
    endtask

    // Idle cycles with stray MEM_RDY pulses that must be ignored
    task automatic idle(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            MEM_RDY = 1'($urandom);
            @(negedge CLK);
            n_checks++;
            if ({DS_VAL, WR_ACK, MEM_REQ, REQ_RDY} !== 4'b0001) begin
                n_fail++;
                $display("FAIL %s idle c%0d: got dsv=%b ack=%b req=%b rdy=%b exp 0 0 0 1",
                         tag, c, DS_VAL, WR_ACK, MEM_REQ, REQ_RDY);
            end
        end
        MEM_RDY = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({REQ_RDY, MEM_REQ, MEM_WE, DS_VAL, DS_LAST, WR_ACK, MEM_ADDR, MEM_WDATA, DS_DATA, DS_WORD} !==
            {1'b1, 5'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, {DATA_W{1'b0}}, {OFS_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b req=%b we=%b dsv=%b last=%b ack=%b addr=%h wd=%h dd=%h dw=%0d exp rdy=1 rest 0",
                     REQ_RDY, MEM_REQ, MEM_WE, DS_VAL, DS_LAST, WR_ACK, MEM_ADDR, MEM_WDATA, DS_DATA, DS_WORD);
        end
        RESET_N = 1'b1;
        idle(2, "post_reset");
    endtask

    task automatic test_aligned_fill();
        g_key = $urandom;
        run_read(30'h100, 1'b1, 0, 0, "aligned_fill");
        idle(2, "aligned_fill");
    endtask

    task automatic test_critical_word();
        g_key = $urandom;
        run_read(30'h106, 1'b1, 3, 3, "critical_fill");
        idle(2, "critical_fill");
    endtask

    task automatic test_uncached();
        g_key = 32'hDEADBEEF ^ (32'h00002003 * 32'h9E3779B1);
        run_read(30'h2003, 1'b0, 0, 2, "uncached");
        n_checks++;
        if (DS_DATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL uncached_data: got %h exp deadbeef", DS_DATA); end
        idle(2, "uncached");
    endtask

    task automatic test_write();
        run_write(30'h40, 32'h55AA, 1, 3, "write");
        idle(2, "write");
    endtask

    task automatic test_back_to_back();
        g_key = $urandom;
        run_read(30'h3F1, 1'b1, 0, 0, "b2b_fill0");
        run_read(30'h20A, 1'b1, 0, 1, "b2b_fill1");
        run_read(30'h777, 1'b0, 0, 0, "b2b_single");
        run_write(30'h1234, 32'hCAFEF00D, 0, 0, "b2b_write");
        run_read(30'h0FE, 1'b1, 0, 0, "b2b_fill2");
        idle(2, "b2b");
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        for (int t = 0; t < 40; t++) begin
            g_key = $urandom;
            a = ADDR_W'($urandom);
            if ($urandom_range(0, 3) == 0) run_write(a, $urandom, 0, 4, "rand_write");
            else run_read(a, 1'($urandom), 0, 4, "rand_read");
            idle($urandom_range(0, 3), "rand_gap");
        end
    endtask

    task automatic test_reset_mid();
        g_key = $urandom;
        REQ_VAL = 1'b1; REQ_WR = 1'b0; REQ_LINE = 1'b1; REQ_ADDR = 30'h300;
        @(negedge CLK);
        REQ_VAL = 1'b0;
        MEM_RDY = 1'b1; MEM_RDATA = mdata(30'h300);
        @(negedge CLK);
        MEM_RDY = 1'b0;
        n_checks++;
        if ({DS_VAL, MEM_REQ, MEM_ADDR} !== {1'b1, 1'b1, 30'h301}) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got dsv=%b req=%b addr=%h exp 1 1 301", DS_VAL, MEM_REQ, MEM_ADDR);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({REQ_RDY, MEM_REQ, MEM_WE, DS_VAL, DS_LAST, WR_ACK, MEM_ADDR, MEM_WDATA, DS_DATA, DS_WORD} !==
            {1'b1, 5'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, {DATA_W{1'b0}}, {OFS_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL rst_mid_async: got rdy=%b req=%b we=%b dsv=%b last=%b ack=%b addr=%h wd=%h dd=%h dw=%0d exp rdy=1 rest 0",
                     REQ_RDY, MEM_REQ, MEM_WE, DS_VAL, DS_LAST, WR_ACK, MEM_ADDR, MEM_WDATA, DS_DATA, DS_WORD);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        idle(6, "rst_mid_after");
        run_read(30'h305, 1'b1, 0, 1, "rst_mid_recover");
        idle(1, "rst_mid_recover");
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_aligned_fill();
        test_critical_word();
        test_uncached();
        test_write();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
